moore_seq_gen: RTL and testbench

Serial bit-pattern generator that produces the x1 stimulus stream consumed by the Moore sequence detector. It is the transmitting end of that one-bit-per-clock interface. A programmed pattern of 1..MAX_LEN bits is shifted out MSB-first, one bit per clock. The frame can be repeated with a programmable idle gap between repetitions. It sits on-chip as a built-in self-test source, or in benches as a synthesizable driver feeding the detector's x1 input.

---
 rtl/moore_seq_pkg.sv | 23 ++
 rtl/moore_seq_shreg.sv | 32 +++
 rtl/moore_seq_gen.sv | 193 +++++++++++++++++++
 tb/tb_moore_seq_gen.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/moore_seq_pkg.sv
// Shared types and helpers for the Moore-detector stimulus generator.
// Holds the FSM encoding, the default idle level and the length clamp.
package moore_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        FIN   = 2'd3
    } seq_state_t;

    localparam logic IDLE_LVL_DEF = 1'b0;

    // Requested lengths beyond the register width are sent as a full-width frame.
    function automatic int clamp_len(input int raw_len, input int max_len);
        if (raw_len > max_len) begin
            return max_len;
        end else begin
            return raw_len;
        end
    endfunction

endpackage

// File: rtl/moore_seq_shreg.sv
// Loadable left-shift register; msb is the next pattern bit to be presented.
module moore_seq_shreg
    import moore_seq_pkg::*;
#(
    parameter int MAX_LEN = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               shift,
    input  logic [MAX_LEN-1:0] load_val,
    output logic               msb
);

    logic [MAX_LEN-1:0] data_r;

    // Load has priority over shift; zeros fill from the right.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r <= '0;
        end else if (load) begin
            data_r <= load_val;
        end else if (shift) begin
            data_r <= {data_r[MAX_LEN-2:0], 1'b0};
        end else begin
            data_r <= data_r;
        end
    end

    assign msb = data_r[MAX_LEN-1];

endmodule

// File: rtl/moore_seq_gen.sv
// Serial MSB-first pattern generator driving the Moore detector's x1 input,
// with programmable length, repeat count and inter-frame idle gap.
module moore_seq_gen
    import moore_seq_pkg::*;
#(
    parameter int   MAX_LEN  = 8,
    parameter int   LEN_W    = 4,
    parameter int   REP_W    = 4,
    parameter int   GAP_W    = 4,
    parameter logic IDLE_LVL = IDLE_LVL_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic [REP_W-1:0]   rep,
    input  logic [GAP_W-1:0]   gap,
    output logic               x_out,
    output logic               x_valid,
    output logic               frame_start,
    output logic               busy,
    output logic               done
);

    seq_state_t         state_r, state_nx;
    logic               x_out_r, x_out_nx;
    logic               x_valid_r, x_valid_nx;
    logic               frame_start_r, frame_start_nx;
    logic               busy_r, busy_nx;
    logic               done_r, done_nx;
    logic [LEN_W-1:0]   bit_cnt_r, bit_cnt_nx;
    logic [REP_W-1:0]   rep_cnt_r, rep_cnt_nx;
    logic [GAP_W-1:0]   gap_cnt_r, gap_cnt_nx;
    logic [LEN_W-1:0]   len_r, len_nx;
    logic [GAP_W-1:0]   gap_r, gap_nx;
    logic [MAX_LEN-1:0] pat_r, pat_nx;

    logic [LEN_W-1:0]   len_c_s;
    logic [MAX_LEN-1:0] aligned_s;
    logic               sr_load_s;
    logic               sr_shift_s;
    logic [MAX_LEN-1:0] sr_load_val_s;
    logic               sr_msb_s;

    // The pattern is stored left-aligned so its first bit always sits at the msb.
    assign len_c_s   = LEN_W'(clamp_len(int'(len), MAX_LEN));
    assign aligned_s = pattern << (MAX_LEN - int'(len_c_s));

    moore_seq_shreg #(
        .MAX_LEN (MAX_LEN)
    ) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .load     (sr_load_s),
        .shift    (sr_shift_s),
        .load_val (sr_load_val_s),
        .msb      (sr_msb_s)
    );

    // Next-state and next-output logic; the shift register holds the bits after the one on x_out.
    always_comb begin
        state_nx       = state_r;
        x_out_nx       = IDLE_LVL;
        x_valid_nx     = 1'b0;
        frame_start_nx = 1'b0;
        busy_nx        = 1'b0;
        done_nx        = 1'b0;
        bit_cnt_nx     = bit_cnt_r;
        rep_cnt_nx     = rep_cnt_r;
        gap_cnt_nx     = gap_cnt_r;
        len_nx         = len_r;
        gap_nx         = gap_r;
        pat_nx         = pat_r;
        sr_load_s      = 1'b0;
        sr_shift_s     = 1'b0;
        sr_load_val_s  = {pat_r[MAX_LEN-2:0], 1'b0};

        case (state_r)
            IDLE: begin
                if (start) begin
                    len_nx     = len_c_s;
                    gap_nx     = gap;
                    pat_nx     = aligned_s;
                    rep_cnt_nx = rep;
                    if (len_c_s == '0) begin
                        state_nx = FIN;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx       = SHIFT;
                        x_out_nx       = aligned_s[MAX_LEN-1];
                        x_valid_nx     = 1'b1;
                        frame_start_nx = 1'b1;
                        busy_nx        = 1'b1;
                        bit_cnt_nx     = len_c_s - LEN_W'(1);
                        sr_load_s      = 1'b1;
                        sr_load_val_s  = {aligned_s[MAX_LEN-2:0], 1'b0};
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (bit_cnt_r != '0) begin
                    bit_cnt_nx = bit_cnt_r - LEN_W'(1);
                    x_out_nx   = sr_msb_s;
                    x_valid_nx = 1'b1;
                    busy_nx    = 1'b1;
                    sr_shift_s = 1'b1;
                end else if (rep_cnt_r != '0) begin
                    rep_cnt_nx = rep_cnt_r - REP_W'(1);
                    busy_nx    = 1'b1;
                    if (gap_r != '0) begin
                        state_nx   = GAP;
                        gap_cnt_nx = gap_r;
                    end else begin
                        x_out_nx       = pat_r[MAX_LEN-1];
                        x_valid_nx     = 1'b1;
                        frame_start_nx = 1'b1;
                        bit_cnt_nx     = len_r - LEN_W'(1);
                        sr_load_s      = 1'b1;
                    end
                end else begin
                    state_nx = FIN;
                    done_nx  = 1'b1;
                end
            end
            GAP: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (gap_cnt_r == GAP_W'(1)) begin
                    state_nx       = SHIFT;
                    x_out_nx       = pat_r[MAX_LEN-1];
                    x_valid_nx     = 1'b1;
                    frame_start_nx = 1'b1;
                    busy_nx        = 1'b1;
                    bit_cnt_nx     = len_r - LEN_W'(1);
                    sr_load_s      = 1'b1;
                end else begin
                    gap_cnt_nx = gap_cnt_r - GAP_W'(1);
                    busy_nx    = 1'b1;
                end
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, counters, captured configuration and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            x_out_r       <= IDLE_LVL;
            x_valid_r     <= 1'b0;
            frame_start_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            bit_cnt_r     <= '0;
            rep_cnt_r     <= '0;
            gap_cnt_r     <= '0;
            len_r         <= '0;
            gap_r         <= '0;
            pat_r         <= '0;
        end else begin
            state_r       <= state_nx;
            x_out_r       <= x_out_nx;
            x_valid_r     <= x_valid_nx;
            frame_start_r <= frame_start_nx;
            busy_r        <= busy_nx;
            done_r        <= done_nx;
            bit_cnt_r     <= bit_cnt_nx;
            rep_cnt_r     <= rep_cnt_nx;
            gap_cnt_r     <= gap_cnt_nx;
            len_r         <= len_nx;
            gap_r         <= gap_nx;
            pat_r         <= pat_nx;
        end
    end

    assign x_out       = x_out_r;
    assign x_valid     = x_valid_r;
    assign frame_start = frame_start_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_moore_seq_gen.sv
// Directed bench for moore_seq_gen: expected per-cycle output tuples are hand-written,
// left-to-right in time, starting with the cycle after the accepting edge.
module tb_moore_seq_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] pattern = 8'h00;
    logic [3:0] len = 4'd0;
    logic [3:0] rep = 4'd0;
    logic [3:0] gap = 4'd0;
    logic       x_out;
    logic       x_valid;
    logic       frame_start;
    logic       busy;
    logic       done;

    int n_chk  = 0;
    int n_pass = 0;

    moore_seq_gen dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .pattern     (pattern),
        .len         (len),
        .rep         (rep),
        .gap         (gap),
        .x_out       (x_out),
        .x_valid     (x_valid),
        .frame_start (frame_start),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Each vector is read MSB-first, one bit per cycle; tuple is {x_out,x_valid,frame_start,busy,done}.
    task automatic expect_seq(input string tag, input int n,
                              input logic [31:0] xo, input logic [31:0] xv,
                              input logic [31:0] fs, input logic [31:0] bz,
                              input logic [31:0] dn);
        for (int i = 0; i < n; i++) begin
            chk_eq($sformatf("%s_c%0d", tag, i),
                   {27'd0, x_out, x_valid, frame_start, busy, done},
                   {27'd0, xo[n-1-i], xv[n-1-i], fs[n-1-i], bz[n-1-i], dn[n-1-i]});
            tick();
        end
    endtask

    task automatic go(input logic [7:0] p, input logic [3:0] l,
                      input logic [3:0] r, input logic [3:0] g);
        pattern = p;
        len     = l;
        rep     = r;
        gap     = g;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        chk_eq("rst_x_out", {31'd0, x_out}, 32'd0);
        chk_eq("rst_x_valid", {31'd0, x_valid}, 32'd0);
        chk_eq("rst_frame_start", {31'd0, frame_start}, 32'd0);
        chk_eq("rst_busy", {31'd0, busy}, 32'd0);
        chk_eq("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        tick();

        // 1: four bits 1,0,1,1 then FIN then idle
        go(8'b0000_1011, 4'd4, 4'd0, 4'd0);
        expect_seq("s1", 6, 32'b101100, 32'b111100, 32'b100000, 32'b111100, 32'b000010);

        // 2: two frames of 1,0,1 separated by two idle cycles
        go(8'b0000_0101, 4'd3, 4'd1, 4'd2);
        expect_seq("s2", 10, 32'b1010010100, 32'b1110011100, 32'b1000010000,
                   32'b1111111100, 32'b0000000010);

        // 3a: zero length sends nothing but still completes
        go(8'hFF, 4'd0, 4'd0, 4'd0);
        expect_seq("s3a", 3, 32'b000, 32'b000, 32'b000, 32'b000, 32'b100);

        // 3b: length 12 is clamped to the full 8 bits
        go(8'b1100_1010, 4'd12, 4'd0, 4'd0);
        expect_seq("s3b", 10, 32'b1100101000, 32'b1111111100, 32'b1000000000,
                   32'b1111111100, 32'b0000000010);

        // 4: start re-pulsed with new settings while shifting is ignored
        go(8'b0000_0110, 4'd3, 4'd0, 4'd0);
        pattern = 8'h01;
        len     = 4'd5;
        rep     = 4'd3;
        start   = 1'b1;
        expect_seq("s4a", 1, 32'b1, 32'b1, 32'b1, 32'b1, 32'b0);
        start   = 1'b0;
        expect_seq("s4b", 5, 32'b10000, 32'b11000, 32'b00000, 32'b11000, 32'b00100);

        // 5: abort on the third bit, then start+abort together in IDLE
        go(8'b1010_0101, 4'd8, 4'd0, 4'd0);
        expect_seq("s5a", 2, 32'b10, 32'b11, 32'b10, 32'b11, 32'b00);
        abort = 1'b1;
        expect_seq("s5b", 1, 32'b1, 32'b1, 32'b0, 32'b1, 32'b0);
        abort = 1'b0;
        expect_seq("s5c", 2, 32'b00, 32'b00, 32'b00, 32'b00, 32'b00);
        abort = 1'b1;
        go(8'h3C, 4'd8, 4'd0, 4'd0);
        abort = 1'b0;
        expect_seq("s5d", 10, 32'b0011110000, 32'b1111111100, 32'b1000000000,
                   32'b1111111100, 32'b0000000010);

        // 6: reset in the middle of the gap, then a fresh frame as in 1
        go(8'b0000_0101, 4'd3, 4'd1, 4'd2);
        expect_seq("s6a", 4, 32'b1010, 32'b1110, 32'b1000, 32'b1111, 32'b0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_seq("s6b", 2, 32'b00, 32'b00, 32'b00, 32'b00, 32'b00);
        go(8'b0000_1011, 4'd4, 4'd0, 4'd0);
        expect_seq("s6c", 6, 32'b101100, 32'b111100, 32'b100000, 32'b111100, 32'b000010);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
